alu_arb_ctrl: RTL and testbench

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

---
 rtl/alu_arb_ctrl_if.sv | 38 +++
 rtl/alu_arb_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_alu_arb_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_ctrl_if.sv
// Requester/response bundle between two requesters and the alu_arb_ctrl arbiter.
// master: requester side; slave: arbiter side.
interface alu_arb_ctrl_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [63:0] req0_x;
    logic [63:0] req0_y;
    logic [1:0]  req0_ops;
    logic [2:0]  req0_mode;
    logic        req1_valid;
    logic        req1_ready;
    logic [63:0] req1_x;
    logic [63:0] req1_y;
    logic [1:0]  req1_ops;
    logic [2:0]  req1_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_z;
    logic [3:0]  rsp_ovf;
    logic        rsp_err;

    modport master (
        output req0_valid, req0_x, req0_y, req0_ops, req0_mode,
        output req1_valid, req1_x, req1_y, req1_ops, req1_mode,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_z, rsp_ovf, rsp_err
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_ops, req0_mode,
        input  req1_valid, req1_x, req1_y, req1_ops, req1_mode,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_z, rsp_ovf, rsp_err
    );
endinterface

// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end for a shared multi-cycle lane ALU.
// One operation in flight; illegal op/mode codes bypass the ALU with an error response.
module alu_arb_ctrl #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    alu_arb_ctrl_if.slave bus,
    output logic [63:0]   alu_x,
    output logic [63:0]   alu_y,
    output logic [1:0]    alu_ops,
    output logic [2:0]    alu_mode,
    input  logic [63:0]   alu_z,
    input  logic [3:0]    alu_ovf,
    output logic [15:0]   done_count
);
    localparam logic [1:0] WaitLoad = 2'(ALU_LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StResp} state_e;

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic        id_q, id_d;
    logic [63:0] x_q, x_d, y_q, y_d;
    logic [1:0]  ops_q, ops_d;
    logic [2:0]  mode_q, mode_d;
    logic [63:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d;
    logic [1:0]  alu_ops_q, alu_ops_d;
    logic [2:0]  alu_mode_q, alu_mode_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] rsp_z_q, rsp_z_d;
    logic [3:0]  rsp_ovf_q, rsp_ovf_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] done_q, done_d;

    logic        grant0, grant1, illegal;
    logic [3:0]  ovf_mask;

    // rr_q == 0 gives requester 0 priority when both are valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle) begin
            if (bus.req0_valid && (!bus.req1_valid || !rr_q)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign illegal = (ops_q == 2'b11) || (mode_q > 3'b010);

    always_comb begin
        case (mode_q)
            3'b000:  ovf_mask = 4'b0001;
            3'b001:  ovf_mask = 4'b0011;
            default: ovf_mask = 4'b1111;
        endcase
        if (ops_q == 2'b10) ovf_mask = 4'b0000;
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        x_d        = x_q;
        y_d        = y_q;
        ops_d      = ops_q;
        mode_d     = mode_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        alu_ops_d  = alu_ops_q;
        alu_mode_d = alu_mode_q;
        cnt_d      = cnt_q;
        rsp_z_d    = rsp_z_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_err_d  = rsp_err_q;
        done_d     = done_q;
        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    id_d    = grant1;
                    rr_d    = grant0;
                    x_d     = grant1 ? bus.req1_x    : bus.req0_x;
                    y_d     = grant1 ? bus.req1_y    : bus.req0_y;
                    ops_d   = grant1 ? bus.req1_ops  : bus.req0_ops;
                    mode_d  = grant1 ? bus.req1_mode : bus.req0_mode;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (illegal) begin
                    rsp_z_d   = '0;
                    rsp_ovf_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    alu_x_d    = x_q;
                    alu_y_d    = y_q;
                    alu_ops_d  = ops_q;
                    alu_mode_d = mode_q;
                    cnt_d      = WaitLoad;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 2'd0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StCapture: begin
                rsp_z_d   = alu_z;
                rsp_ovf_d = alu_ovf & ovf_mask;
                rsp_err_d = 1'b0;
                state_d   = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    if (done_q != 16'hFFFF) done_d = done_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            id_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            ops_q      <= '0;
            mode_q     <= '0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            alu_ops_q  <= '0;
            alu_mode_q <= '0;
            cnt_q      <= '0;
            rsp_z_q    <= '0;
            rsp_ovf_q  <= '0;
            rsp_err_q  <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ops_q      <= ops_d;
            mode_q     <= mode_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            alu_ops_q  <= alu_ops_d;
            alu_mode_q <= alu_mode_d;
            cnt_q      <= cnt_d;
            rsp_z_q    <= rsp_z_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_err_q  <= rsp_err_d;
            done_q     <= done_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign bus.rsp_err    = rsp_err_q;
    assign alu_x          = alu_x_q;
    assign alu_y          = alu_y_q;
    assign alu_ops        = alu_ops_q;
    assign alu_mode       = alu_mode_q;
    assign done_count     = done_q;
endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed bench for alu_arb_ctrl: vector table of single operations plus
// reset-mid-op, contention and backpressure sequences against a behavioural lane ALU.
module tb_alu_arb_ctrl;
    localparam int Lat = 1;

    typedef struct {
        logic        id;
        logic [63:0] x;
        logic [63:0] y;
        logic [1:0]  ops;
        logic [2:0]  mode;
        logic [63:0] z;
        logic [3:0]  ovf;
        logic        err;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic [63:0] alu_x, alu_y, alu_z;
    logic [1:0]  alu_ops;
    logic [2:0]  alu_mode;
    logic [3:0]  alu_ovf;
    logic [15:0] done_count;

    int n_pass;
    int n_total;
    int exp_done;

    vec_t vecs[10];

    alu_arb_ctrl_if bus ();

    alu_arb_ctrl #(.ALU_LATENCY(Lat)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_ops    (alu_ops),
        .alu_mode   (alu_mode),
        .alu_z      (alu_z),
        .alu_ovf    (alu_ovf),
        .done_count (done_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Lane ALU; carry bits of unused lanes and of max are driven high so masking is visible.
    function automatic logic [67:0] alu_model(input logic [63:0] x, input logic [63:0] y,
                                              input logic [1:0] ops, input logic [2:0] mode);
        logic [63:0] z;
        logic [3:0]  c;
        logic [64:0] m, a, b, r;
        int          w;
        z = '0;
        c = 4'b1111;
        w = (mode == 3'b000) ? 64 : (mode == 3'b001) ? 32 : 16;
        m = (65'd1 << w) - 65'd1;
        for (int l = 0; l < 64 / w; l++) begin
            a = {1'b0, x >> (l * w)} & m;
            b = {1'b0, y >> (l * w)} & m;
            if (ops == 2'b00) begin
                r = a + b;
                c[l] = r[w];
            end else if (ops == 2'b01) begin
                r = (a - b) & m;
                c[l] = (a < b);
            end else begin
                r = (a > b) ? a : b;
            end
            z = z | ((r[63:0] & m[63:0]) << (l * w));
        end
        return {c, z};
    endfunction

    always_comb {alu_ovf, alu_z} = alu_model(alu_x, alu_y, alu_ops, alu_mode);

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic id, input logic valid, input vec_t v);
        if (id) begin
            bus.req1_valid = valid;
            bus.req1_x     = v.x;
            bus.req1_y     = v.y;
            bus.req1_ops   = v.ops;
            bus.req1_mode  = v.mode;
        end else begin
            bus.req0_valid = valid;
            bus.req0_x     = v.x;
            bus.req0_y     = v.y;
            bus.req0_ops   = v.ops;
            bus.req0_mode  = v.mode;
        end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        logic [68:0] alu_before;
        int          n;
        alu_before = {alu_x, alu_ops, alu_mode};
        @(negedge clock);
        bus.rsp_ready = 1'b1;
        drive(v.id, 1'b1, v);
        #1;
        check({tag, "_grant"}, {bus.req1_ready, bus.req0_ready}, v.id ? 2'b10 : 2'b01);
        @(posedge clock);
        #1;
        drive(v.id, 1'b0, v);
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, v.err ? 2 : 3 + Lat);
        check({tag, "_z"}, bus.rsp_z, v.z);
        check({tag, "_ovf"}, bus.rsp_ovf, v.ovf);
        check({tag, "_err"}, bus.rsp_err, v.err);
        check({tag, "_id"}, bus.rsp_id, v.id);
        if (v.err) check({tag, "_alu_held"}, {alu_x, alu_ops, alu_mode}, alu_before);
        exp_done++;
        @(posedge clock);
        #1;
        check({tag, "_rsp_drop"}, bus.rsp_valid, 1'b0);
        check({tag, "_done"}, done_count, exp_done);
    endtask

    initial begin
        vec_t va, vb, vbp;
        logic [3:0]  gseq, rseq;
        logic [71:0] snap;
        int          ngr, nrs, cyc, last_g;

        n_pass   = 0;
        n_total  = 0;
        exp_done = 0;

        vecs[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 3'b000,
                    64'h0, 4'b0001, 1'b0};
        vecs[1] = '{1'b1, 64'h0000_0005_0010_FFFF, 64'h0001_0003_0020_0001, 2'b01, 3'b010,
                    64'hFFFF_0002_FFF0_FFFE, 4'b1010, 1'b0};
        vecs[2] = '{1'b0, 64'hFFFF_FFFF_0000_0001, 64'h0000_0001_FFFF_FFFF, 2'b00, 3'b001,
                    64'h0, 4'b0011, 1'b0};
        vecs[3] = '{1'b1, 64'h8000_0000_7FFF_FFFF, 64'h8000_0000_0000_0001, 2'b00, 3'b001,
                    64'h0000_0000_8000_0000, 4'b0010, 1'b0};
        vecs[4] = '{1'b0, 64'h0001_FFFF_8000_0003, 64'h0002_0001_7FFF_0004, 2'b10, 3'b010,
                    64'h0002_FFFF_8000_0004, 4'b0000, 1'b0};
        vecs[5] = '{1'b1, 64'h0, 64'h1, 2'b01, 3'b000,
                    64'hFFFF_FFFF_FFFF_FFFF, 4'b0001, 1'b0};
        vecs[6] = '{1'b0, 64'h5, 64'h3, 2'b10, 3'b000, 64'h5, 4'b0000, 1'b0};
        vecs[7] = '{1'b0, 64'h1234, 64'h1, 2'b11, 3'b000, 64'h0, 4'b0000, 1'b1};
        vecs[8] = '{1'b1, 64'h1234, 64'h1, 2'b00, 3'b011, 64'h0, 4'b0000, 1'b1};
        vecs[9] = '{1'b0, 64'h0000_0001_0000_FFFF, 64'h0000_0001_0000_0001, 2'b00, 3'b010,
                    64'h0000_0002_0000_0000, 4'b0001, 1'b0};

        va  = '{1'b0, 64'h10, 64'h20, 2'b00, 3'b000, 64'h30, 4'b0000, 1'b0};
        vb  = '{1'b1, 64'h20, 64'h10, 2'b01, 3'b000, 64'h10, 4'b0000, 1'b0};
        vbp = '{1'b0, 64'h0000_0001_FFFF_FFFF, 64'h0000_0001_0000_0001, 2'b00, 3'b001,
                64'h0000_0002_0000_0000, 4'b0001, 1'b0};

        reset_n       = 1'b0;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b0, va);
        drive(1'b1, 1'b0, vb);
        #12;
        check("reset_outputs", {bus.rsp_valid, bus.rsp_id, bus.rsp_z, bus.rsp_ovf, bus.rsp_err,
                                alu_x, alu_y, alu_ops, alu_mode, done_count}, '0);
        check("reset_ready_idle", {bus.req1_ready, bus.req0_ready}, 2'b00);
        bus.req0_valid = 1'b1;
        #1;
        check("reset_ready_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        bus.req0_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) do_op(vecs[i], $sformatf("v%0d", i));

        // Abandon an op in WAIT; rr pointer is left at requester 1 beforehand.
        @(negedge clock);
        drive(1'b0, 1'b1, va);
        @(posedge clock);
        #1;
        drive(1'b0, 1'b0, va);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("midop_reset_outputs", {bus.rsp_valid, bus.rsp_id, bus.rsp_z, bus.rsp_ovf,
                                      bus.rsp_err, alu_x, alu_y, alu_ops, alu_mode,
                                      done_count}, '0);
        drive(1'b0, 1'b1, va);
        drive(1'b1, 1'b1, vb);
        repeat (3) @(posedge clock);
        #1;
        check("held_reset_outputs", {bus.rsp_valid, alu_x, done_count}, '0);
        check("held_reset_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
        exp_done = 0;

        @(negedge clock);
        reset_n       = 1'b1;
        bus.rsp_ready = 1'b1;
        gseq = '0;
        rseq = '0;
        ngr = 0;
        nrs = 0;
        cyc = 0;
        last_g = 0;
        while (nrs < 4 && cyc < 200) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                gseq = {gseq[2:0], bus.req1_ready};
                if (ngr > 0) check($sformatf("rr_gap%0d", ngr), cyc - last_g, 4 + Lat);
                last_g = cyc;
                ngr++;
            end
            if (bus.rsp_valid) begin
                rseq = {rseq[2:0], bus.rsp_id};
                nrs++;
            end
            if (nrs < 4) begin
                @(negedge clock);
                cyc++;
            end
        end
        drive(1'b0, 1'b0, va);
        drive(1'b1, 1'b0, vb);
        check("rr_grant_count", ngr, 4);
        check("rr_grant_order", gseq, 4'b0101);
        check("rr_rsp_order", rseq, 4'b0101);
        exp_done += 4;
        @(posedge clock);
        #1;
        check("rr_done", done_count, exp_done);

        @(negedge clock);
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b1, vbp);
        drive(1'b1, 1'b1, vb);
        #1;
        check("bp_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(posedge clock);
        #1;
        drive(1'b0, 1'b0, vbp);
        cyc = 0;
        while (!bus.rsp_valid && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("bp_rsp_seen", bus.rsp_valid, 1'b1);
        snap = {bus.rsp_z, bus.rsp_ovf, bus.rsp_id, bus.rsp_err, 2'b00};
        check("bp_rsp_value", snap, {vbp.z, vbp.ovf, 1'b0, 1'b0, 2'b00});
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("bp_hold%0d", i),
                  {bus.rsp_valid, bus.rsp_z, bus.rsp_ovf, bus.rsp_id, bus.rsp_err,
                   bus.req0_ready, bus.req1_ready},
                  {1'b1, snap[71:2], 2'b00});
        end
        @(negedge clock);
        bus.rsp_ready = 1'b1;
        exp_done++;
        @(posedge clock);
        #1;
        check("bp_release_valid", bus.rsp_valid, 1'b0);
        check("bp_release_done", done_count, exp_done);
        check("bp_next_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
        drive(1'b1, 1'b0, vb);
        repeat (2) @(posedge clock);
        #1;
        check("final_idle", {bus.rsp_valid, done_count}, {1'b0, 16'(exp_done)});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
